// File: rtl/gate_vector_driver_if.sv
// Bundles the self-test handshake and result signals of gate_vector_driver.
// master = the driver block, slave = whatever observes it and supplies gate_in.
interface gate_vector_driver_if;
    logic       start;
    logic       gate_in;
    logic       a_out;
    logic       b_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic       mismatch;
    logic [7:0] err_count;
    logic [1:0] last_fail_vec;

    modport master (
        input  start, gate_in,
        output a_out, b_out, busy, done, pass, mismatch, err_count, last_fail_vec
    );

    modport slave (
        output start, gate_in,
        input  a_out, b_out, busy, done, pass, mismatch, err_count, last_fail_vec
    );
endinterface

// File: rtl/gate_vector_driver.sv
// Sweeps a 2-input gate through 00,01,10,11 (LOOPS times), checks gate_in against GATE_FUNC.
// Latency: first vector one edge after start; sweep lasts 4*LOOPS*HOLD_CYCLES cycles.
// Backpressure: none; start is only honoured in IDLE/DONE and ignored while running.
module gate_vector_driver #(
    parameter int unsigned HOLD_CYCLES   = 4,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned LOOPS         = 1,
    parameter logic [3:0]  GATE_FUNC     = 4'b1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gate_vector_driver_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] SAMPLE_AT = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] LOOP_LAST = 8'(LOOPS - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_vec;
    logic [7:0] r_hold;
    logic [7:0] r_loop;
    logic       r_busy;
    logic       r_done;
    logic       r_mismatch;
    logic [7:0] r_err;
    logic [1:0] r_last;

    logic       w_start_acc;
    logic       w_vec_end;
    logic       w_sweep_end;
    logic       w_sample;
    logic       w_fail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // r_hold counts edges since the current vector was applied.
    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        w_vec_end   = 1'b0;
        w_sweep_end = 1'b0;
        w_sample    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_sample  = (r_hold == SAMPLE_AT);
                w_vec_end = (r_hold == HOLD_LAST);
                if (w_vec_end && (r_vec == 2'b11) && (r_loop == LOOP_LAST)) begin
                    w_sweep_end = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_fail = w_sample && (bus.gate_in != GATE_FUNC[r_vec]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec      <= 2'b00;
            r_hold     <= 8'd0;
            r_loop     <= 8'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mismatch <= 1'b0;
            r_err      <= 8'd0;
            r_last     <= 2'b00;
        end else begin
            r_mismatch <= w_fail;
            if (w_start_acc) begin
                r_vec  <= 2'b00;
                r_hold <= 8'd0;
                r_loop <= 8'd0;
                r_busy <= 1'b1;
                r_done <= 1'b0;
                r_err  <= 8'd0;
                r_last <= 2'b00;
            end else if (r_state == S_RUN) begin
                if (w_vec_end) begin
                    r_hold <= 8'd0;
                    r_vec  <= r_vec + 2'd1;
                    if (r_vec == 2'b11) r_loop <= r_loop + 8'd1;
                end else begin
                    r_hold <= r_hold + 8'd1;
                end
                // Vector wraps 11 -> 00 on its own, so a/b return to 0 at sweep end.
                if (w_sweep_end) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_loop <= 8'd0;
                end
                if (w_fail) begin
                    if (r_err != 8'hFF) r_err <= r_err + 8'd1;
                    r_last <= r_vec;
                end
            end
        end
    end

    assign bus.a_out         = r_vec[1];
    assign bus.b_out         = r_vec[0];
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.mismatch      = r_mismatch;
    assign bus.err_count     = r_err;
    assign bus.last_fail_vec = r_last;
    assign bus.pass          = r_done && (r_err == 8'd0);

endmodule

// File: tb/tb_gate_vector_driver.sv
// Self-checking bench: three driver instances (defaults, LOOPS=3, saturation setup)
// checked cycle by cycle against a timeline model of the sweep.
module tb_gate_vector_driver;

    logic clk;
    logic rst_n;

    gate_vector_driver_if if0();
    gate_vector_driver_if if1();
    gate_vector_driver_if if2();

    gate_vector_driver u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.master));
    gate_vector_driver #(.LOOPS(3)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));
    gate_vector_driver #(.HOLD_CYCLES(2), .SETTLE_CYCLES(1), .LOOPS(255), .GATE_FUNC(4'b0111))
        u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.master));

    localparam int         HOLD_P   [3] = '{4, 4, 2};
    localparam int         SETTLE_P [3] = '{2, 2, 1};
    localparam int         LOOPS_P  [3] = '{1, 3, 255};
    localparam logic [3:0] FUNC_P   [3] = '{4'b1000, 4'b1000, 4'b0111};

    // gate models: 0 = AND, 1 = stuck at 1, 2 = random, 3 = OR
    logic [2:0] t_start;
    logic [2:0] t_rnd;
    logic [2:0] t_gin;
    int         mode_r [3];
    wire  [2:0] t_a = {if2.a_out, if1.a_out, if0.a_out};
    wire  [2:0] t_b = {if2.b_out, if1.b_out, if0.b_out};

    assign if0.start = t_start[0];
    assign if1.start = t_start[1];
    assign if2.start = t_start[2];
    assign if0.gate_in = t_gin[0];
    assign if1.gate_in = t_gin[1];
    assign if2.gate_in = t_gin[2];

    always_comb begin
        t_gin = 3'b000;
        for (int k = 0; k < 3; k++) begin
            case (mode_r[k])
                0:       t_gin[k] = t_a[k] & t_b[k];
                1:       t_gin[k] = 1'b1;
                2:       t_gin[k] = t_rnd[k];
                default: t_gin[k] = t_a[k] | t_b[k];
            endcase
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // {a,b,busy,done,mismatch,pass,err_count[7:0],last_fail_vec[1:0]}
    function automatic logic [15:0] obs(input int k);
        logic [15:0] o;
        o = 16'h0;
        case (k)
            0: o = {if0.a_out, if0.b_out, if0.busy, if0.done, if0.mismatch, if0.pass,
                    if0.err_count, if0.last_fail_vec};
            1: o = {if1.a_out, if1.b_out, if1.busy, if1.done, if1.mismatch, if1.pass,
                    if1.err_count, if1.last_fail_vec};
            default: o = {if2.a_out, if2.b_out, if2.busy, if2.done, if2.mismatch, if2.pass,
                          if2.err_count, if2.last_fail_vec};
        endcase
        return o;
    endfunction

    // Model: cycle c after the start edge holds vector (c/H)%4; a sample happens when
    // c%H == SETTLE using the gate value present in the cycle before.
    task automatic run_sweep(input int k, input int mode, input int glitch, input bit end_start);
        int          h, s, n, err_m;
        logic [1:0]  v, lfv_m;
        logic [3:0]  f;
        logic        g_prev, mis_m;
        logic [15:0] exp_o;
        h = HOLD_P[k];
        s = SETTLE_P[k];
        n = 4 * LOOPS_P[k] * h;
        f = FUNC_P[k];
        err_m = 0;
        lfv_m = 2'b00;
        g_prev = 1'b0;
        mode_r[k] = mode;
        @(negedge clk);
        t_start[k] = 1'b1;
        @(negedge clk);
        for (int c = 0; c <= n; c++) begin
            mis_m = 1'b0;
            v = 2'((c / h) % 4);
            if (c < n && (c % h) == s) begin
                if (g_prev != f[v]) begin
                    mis_m = 1'b1;
                    if (err_m < 255) err_m++;
                    lfv_m = v;
                end
            end
            if (c < n) exp_o = {v, 1'b1, 1'b0, mis_m, 1'b0, 8'(err_m), lfv_m};
            else       exp_o = {2'b00, 1'b0, 1'b1, 1'b0, (err_m == 0), 8'(err_m), lfv_m};
            check("cycle", 32'(obs(k)), 32'(exp_o));
            t_start[k] = (c == glitch) || (end_start && c == n - 1);
            t_rnd[k]   = 1'($urandom);
            case (mode)
                0:       g_prev = v[1] & v[0];
                1:       g_prev = 1'b1;
                2:       g_prev = t_rnd[k];
                default: g_prev = v[1] | v[0];
            endcase
            if (c < n) @(negedge clk);
        end
        if (end_start) begin
            @(negedge clk);
            check("done_hold", 32'(obs(k)), 32'(exp_o));
        end
    endtask

    typedef struct {
        int         dut;
        int         mode;
        int         glitch;
        bit         end_start;
        logic [7:0] err;
        logic [1:0] lfv;
        logic       pass;
    } vec_t;

    vec_t tbl [8];
    logic [15:0] o;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        t_start = 3'b000;
        t_rnd = 3'b000;
        for (int k = 0; k < 3; k++) mode_r[k] = 0;

        tbl[0] = '{dut: 0, mode: 0, glitch: -1, end_start: 0, err: 8'd0,   lfv: 2'b00, pass: 1'b1};
        tbl[1] = '{dut: 0, mode: 1, glitch: -1, end_start: 0, err: 8'd3,   lfv: 2'b10, pass: 1'b0};
        tbl[2] = '{dut: 0, mode: 0, glitch: 3,  end_start: 0, err: 8'd0,   lfv: 2'b00, pass: 1'b1};
        tbl[3] = '{dut: 0, mode: 1, glitch: -1, end_start: 1, err: 8'd3,   lfv: 2'b10, pass: 1'b0};
        tbl[4] = '{dut: 1, mode: 0, glitch: -1, end_start: 0, err: 8'd0,   lfv: 2'b00, pass: 1'b1};
        tbl[5] = '{dut: 1, mode: 1, glitch: -1, end_start: 0, err: 8'd9,   lfv: 2'b10, pass: 1'b0};
        tbl[6] = '{dut: 0, mode: 3, glitch: -1, end_start: 0, err: 8'd2,   lfv: 2'b10, pass: 1'b0};
        tbl[7] = '{dut: 2, mode: 0, glitch: -1, end_start: 0, err: 8'd255, lfv: 2'b11, pass: 1'b0};

        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) check("reset_state", 32'(obs(k)), 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_sweep(tbl[i].dut, tbl[i].mode, tbl[i].glitch, tbl[i].end_start);
            o = obs(tbl[i].dut);
            check("final_result", 32'(o[10:0]), 32'({tbl[i].pass, tbl[i].err, tbl[i].lfv}));
        end

        // Reset during vector 10 with one error already logged (OR gate fails on 01).
        mode_r[0] = 3;
        @(negedge clk);
        t_start[0] = 1'b1;
        @(negedge clk);
        t_start[0] = 1'b0;
        repeat (8) @(negedge clk);
        check("pre_reset", 32'(obs(0)), 32'({2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 2'b01}));
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'(obs(0)), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 32'(obs(0)), 32'h0);
        run_sweep(0, 0, -1, 0);

        for (int r = 0; r < 4; r++) run_sweep(0, 2, -1, 0);
        for (int r = 0; r < 2; r++) run_sweep(1, 2, 5, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gate_vector_driver.md
Name: gate_vector_driver

Overview:
- Upstream stimulus-and-check stage for the two-input demux-based gate blocks, e.g. the AND gate built from a demux.
- Drives the gate's two inputs through all four input combinations in the fixed order 00, 01, 10, 11, then repeats the sweep LOOPS times.
- Samples the gate output once per vector and compares it with a parameterised truth table.
- Reports busy, done, pass and a mismatch count, giving a synthesizable on-chip self-test that replaces hand-written initial-block stimulus.

Parameters:
- HOLD_CYCLES, 4: clock cycles each input vector is held; legal range 2..255.
- SETTLE_CYCLES, 2: cycles after a vector is applied before gate_in is sampled; legal range 1..HOLD_CYCLES-1.
- LOOPS, 1: number of full 4-vector sweeps per start; legal range 1..255.
- GATE_FUNC, 4'b1000: expected truth table, where bit index {a_out,b_out} gives the expected output. 4'b1000 = AND, 4'b1110 = OR, 4'b0110 = XOR.

Ports:
- clk, input, 1: system clock; all state changes on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: begin a sweep; sampled only in IDLE or DONE.
- gate_in, input, 1: output of the gate under test.
- a_out, output, 1: registered gate input a.
- b_out, output, 1: registered gate input b.
- busy, output, 1: high while a sweep is running.
- done, output, 1: sticky; high from sweep end until the next accepted start.
- pass, output, 1: equals done AND (err_count == 0).
- mismatch, output, 1: one-cycle pulse, registered on a failing sample edge.
- err_count, output, 8: mismatch count, saturating at 255.
- last_fail_vec, output, 2: {a,b} of the most recent failing vector.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE.
  - a_out, b_out, busy, done, mismatch = 0; err_count = 0; last_fail_vec = 0.
  - Vector index, hold counter and loop counter = 0.
  - Reset asserted mid-sweep aborts the sweep immediately; nothing is retained.
- States are IDLE, RUN, DONE.
  - IDLE -> RUN on start = 1.
  - RUN -> DONE after the last vector of the last loop.
  - DONE -> RUN on start = 1. err_count, last_fail_vec and done clear, and the sweep restarts at vector 00.
  - start in RUN is ignored.
- Start edge t0:
  - state <= RUN, busy <= 1, {a_out,b_out} <= 00, hold counter <= 0.
  - Latency from start to first vector is one edge.
- Vector timing: each vector is applied at edge t and held for exactly HOLD_CYCLES cycles; the next vector is applied at edge t+HOLD_CYCLES.
  - Order within a loop is 00 -> 01 -> 10 -> 11.
  - After 11, the sequence wraps to 00 and the loop counter increments.
- Sampling: gate_in is sampled at edge t+SETTLE_CYCLES and compared with GATE_FUNC[{a_out,b_out}].
  - On mismatch at that same edge: mismatch <= 1 for one cycle, err_count increments (no increment if already 255), last_fail_vec <= {a_out,b_out}.
  - Exactly one sample is taken per vector; gate_in is ignored at all other times.
- Sweep end: at the edge where the last vector's hold expires (t0 + 4*LOOPS*HOLD_CYCLES):
  - state <= DONE, busy <= 0, done <= 1, a_out = b_out = 0.
  - busy is high for exactly 4*LOOPS*HOLD_CYCLES cycles.
- Simultaneous events:
  - If start arrives in the same cycle that RUN ends, it is ignored; DONE is entered first.
  - A mismatch on the final vector is counted before done rises, so pass reflects it.
- The 8-bit hold counter and loop counter never exceed their parameter limits, so no wrap-around occurs inside a sweep.
- pass is combinational from done and err_count; all other outputs are registered.

Test Plan:
- Defaults, gate_in wired to a correct AND of a_out and b_out, start pulse at cycle 5:
  - a/b sequence 00, 01, 10, 11, each held 4 cycles.
  - busy high for 16 cycles; done = 1, pass = 1, err_count = 0, mismatch never asserts.
- gate_in stuck at 1:
  - mismatch pulses 3 times (vectors 00, 01, 10).
  - err_count = 3, last_fail_vec = 2'b10, done = 1, pass = 0.
- LOOPS = 3 with a correct AND:
  - busy for 48 cycles; 12 vectors applied, repeating 00..11 three times.
  - pass = 1.
- Reset asserted mid-sweep, during vector 10 with err_count = 1:
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, state is IDLE and a new start runs a clean sweep.
- start pulsed again in RUN at cycle 8:
  - Ignored; the sequence is unchanged.
  - start pulsed in DONE restarts, clearing done and err_count on that edge.
- Saturation with GATE_FUNC = 4'b0111 against a correct AND, LOOPS = 255, HOLD_CYCLES = 2:
  - err_count reaches 255 and holds there.
  - mismatch still pulses on every failing vector.
